// File: rtl/spram_banked_pipe_pkg.sv
// spram_pkg: shared FSM states and address/parity helpers for the banked single-port RAM (SPRAM_PARITY_EN uses lane_parity)
package spram_pkg;

    typedef enum logic [1:0] {ST_RST, ST_INIT, ST_READY} state_t;

    localparam int MAX_GRAN = 64;

    function automatic logic lane_parity(input logic [MAX_GRAN-1:0] lane);
        return ^lane;
    endfunction

    function automatic int bank_of(input int addr, input int num_banks);
        return addr % num_banks;
    endfunction

    function automatic int row_of(input int addr, input int num_banks);
        return addr / num_banks;
    endfunction

endpackage

// File: rtl/spram_banked_pipe_bank.sv
// spram_bank: one lane-masked RAM bank with registered read; optional per-lane parity under SPRAM_PARITY_EN
module spram_bank
    import spram_pkg::*;
#(
    parameter int BANK_DEPTH = 68,
    parameter int DATA_WIDTH = 64,
    parameter int BWE_GRAN   = 8,
    parameter int ROW_W      = 7
) (
    input  logic                           clka,
    input  logic                           we,
    input  logic                           re,
    input  logic [ROW_W-1:0]               row,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/BWE_GRAN-1:0] be,
`ifdef SPRAM_PARITY_EN
    output logic [DATA_WIDTH/BWE_GRAN-1:0] rpar,
`endif
    output logic [DATA_WIDTH-1:0]          rdata
);

    localparam int LANES = DATA_WIDTH / BWE_GRAN;

    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];

    // lane-masked write and registered read of the addressed row
    always_ff @(posedge clka) begin
        if (we)
            for (int k = 0; k < LANES; k++)
                if (be[k]) mem[row][k*BWE_GRAN +: BWE_GRAN] <= wdata[k*BWE_GRAN +: BWE_GRAN];
        if (re) rdata <= mem[row];
    end

`ifdef SPRAM_PARITY_EN
    logic [LANES-1:0] par_mem [BANK_DEPTH];

    // even-parity bit per lane, written together with its lane
    always_ff @(posedge clka) begin
        if (we)
            for (int k = 0; k < LANES; k++)
                if (be[k]) par_mem[row][k] <= lane_parity(MAX_GRAN'(wdata[k*BWE_GRAN +: BWE_GRAN]));
        if (re) rpar <= par_mem[row];
    end
`endif

endmodule

// File: rtl/spram_banked_pipe.sv
// spram_banked_pipe: multi-bank byte-masked single-port RAM with read-latency pipe and zero-init FSM; SPRAM_PARITY_EN adds lane parity
module spram_banked_pipe
    import spram_pkg::*;
#(
    parameter int DATA_DEPTH    = 136,
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_BANKS     = 2,
    parameter int RD_DELAY      = 1,
    parameter int BWE_GRAN      = 8,
    parameter int INIT_ON_RESET = 1,
    parameter int ADDR_WIDTH    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
    parameter int BANK_DEPTH    = (DATA_DEPTH + NUM_BANKS - 1) / NUM_BANKS
) (
    input  logic                           clka,
    input  logic                           rst_n,
    input  logic                           req_vld,
    output logic                           req_rdy,
    input  logic                           req_wr,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          req_wdata,
    input  logic [DATA_WIDTH/BWE_GRAN-1:0] req_be,
    output logic                           rsp_vld,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           addr_err,
    output logic                           init_busy,
    output logic                           par_err
);

    localparam int LANES  = DATA_WIDTH / BWE_GRAN;
    localparam int ROW_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int DP     = (RD_DELAY > 1) ? RD_DELAY - 1 : 1;

    state_t                state;
    logic [ROW_W-1:0]      init_row;
    logic                  init_on;
    logic                  acc;
    logic                  in_rng;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [BSEL_W-1:0]     req_bank;
    logic [ROW_W-1:0]      req_row;
    logic [NUM_BANKS-1:0]  bank_we;
    logic [NUM_BANKS-1:0]  bank_re;
    logic [ROW_W-1:0]      bank_row;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [LANES-1:0]      bank_be;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [RD_DELAY-1:0]   vld_p;
    logic [RD_DELAY-1:0]   oor_p;
    logic [BSEL_W-1:0]     bsel_q;
    logic                  wr_err_q;
    logic [DATA_WIDTH:0]   s1;
    logic [DATA_WIDTH:0]   dpipe [DP];
    logic [DATA_WIDTH:0]   s_out;
    logic [DATA_WIDTH-1:0] last_q;

    // request decode and bank port muxing; INIT owns every bank port
    always_comb begin
        init_on    = state == ST_INIT;
        acc        = req_vld & req_rdy;
        in_rng     = int'(req_addr) < DATA_DEPTH;
        wr_ok      = acc & req_wr & in_rng;
        rd_ok      = acc & ~req_wr & in_rng;
        req_bank   = BSEL_W'(bank_of(int'(req_addr), NUM_BANKS));
        req_row    = ROW_W'(row_of(int'(req_addr), NUM_BANKS));
        bank_row   = init_on ? init_row : req_row;
        bank_wdata = init_on ? '0 : req_wdata;
        bank_be    = init_on ? '1 : req_be;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b] = init_on | (wr_ok & (int'(req_bank) == b));
            bank_re[b] = rd_ok & (int'(req_bank) == b);
        end
    end

`ifdef SPRAM_PARITY_EN
    logic [LANES-1:0] bank_rpar [NUM_BANKS];
    logic             perr;

    // recompute lane parity on the selected bank's read data
    always_comb begin
        perr = 1'b0;
        for (int k = 0; k < LANES; k++)
            perr = perr | (lane_parity(MAX_GRAN'(bank_rdata[bsel_q][k*BWE_GRAN +: BWE_GRAN])) != bank_rpar[bsel_q][k]);
        s1 = {perr & ~oor_p[0], oor_p[0] ? '0 : bank_rdata[bsel_q]};
    end
`else
    // first response stage: out-of-range reads return zero
    always_comb begin
        s1 = {1'b0, oor_p[0] ? '0 : bank_rdata[bsel_q]};
    end
`endif

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        spram_bank #(
            .BANK_DEPTH(BANK_DEPTH),
            .DATA_WIDTH(DATA_WIDTH),
            .BWE_GRAN  (BWE_GRAN),
            .ROW_W     (ROW_W)
        ) u_bank (
            .clka (clka),
            .we   (bank_we[g]),
            .re   (bank_re[g]),
            .row  (bank_row),
            .wdata(bank_wdata),
            .be   (bank_be),
`ifdef SPRAM_PARITY_EN
            .rpar (bank_rpar[g]),
`endif
            .rdata(bank_rdata[g])
        );
    end

    // reset/init/ready FSM with registered handshake and busy flags
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RST;
            init_row  <= '0;
            init_busy <= 1'b0;
            req_rdy   <= 1'b0;
        end else if (state == ST_RST) begin
            state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            init_busy <= INIT_ON_RESET != 0;
            req_rdy   <= INIT_ON_RESET == 0;
        end else if (state == ST_INIT) begin
            init_row <= init_row + 1'b1;
            if (init_row == ROW_W'(BANK_DEPTH - 1)) begin
                state     <= ST_READY;
                init_busy <= 1'b0;
                req_rdy   <= 1'b1;
            end
        end
    end

    // read-latency pipe: control rides alongside data, bank select lines up with bank output
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            vld_p    <= '0;
            oor_p    <= '0;
            bsel_q   <= '0;
            wr_err_q <= 1'b0;
            last_q   <= '0;
            for (int i = 0; i < DP; i++) dpipe[i] <= '0;
        end else begin
            vld_p[0] <= acc & ~req_wr;
            oor_p[0] <= acc & ~req_wr & ~in_rng;
            for (int i = 1; i < RD_DELAY; i++) begin
                vld_p[i] <= vld_p[i-1];
                oor_p[i] <= oor_p[i-1];
            end
            bsel_q   <= req_bank;
            wr_err_q <= acc & req_wr & ~in_rng;
            dpipe[0] <= s1;
            for (int i = 1; i < DP; i++) dpipe[i] <= dpipe[i-1];
            if (rsp_vld) last_q <= s_out[DATA_WIDTH-1:0];
        end
    end

    assign s_out     = (RD_DELAY == 1) ? s1 : dpipe[DP-1];
    assign rsp_vld   = vld_p[RD_DELAY-1];
    assign rsp_rdata = rsp_vld ? s_out[DATA_WIDTH-1:0] : last_q;
    assign addr_err  = oor_p[RD_DELAY-1] | wr_err_q;
    assign par_err   = rsp_vld & s_out[DATA_WIDTH];

endmodule

// File: tb/tb_spram_banked_pipe.sv
// tb_spram_banked_pipe: table-driven checks of two instances (read latency 1 and 3) sharing one request bus
module tb_spram_banked_pipe;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp;
        logic        err;
        logic        par;
    } op_t;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_wr = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_be = '0;

    logic        d1_req_rdy, d1_rsp_vld, d1_addr_err, d1_init_busy, d1_par_err;
    logic [63:0] d1_rsp_rdata;
    logic        d3_req_rdy, d3_rsp_vld, d3_addr_err, d3_init_busy, d3_par_err;
    logic [63:0] d3_rsp_rdata;

    int          total = 0;
    int          bad = 0;
    op_t         ops [256];
    op_t         tbl [13];
    logic [63:0] last_exp [4];

    always #5 clka = ~clka;

    spram_banked_pipe #(.RD_DELAY(1)) dut (
        .clka(clka), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(d1_req_rdy),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_vld(d1_rsp_vld), .rsp_rdata(d1_rsp_rdata), .addr_err(d1_addr_err),
        .init_busy(d1_init_busy), .par_err(d1_par_err)
    );

    spram_banked_pipe #(.RD_DELAY(3)) dut3 (
        .clka(clka), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(d3_req_rdy),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_vld(d3_rsp_vld), .rsp_rdata(d3_rsp_rdata), .addr_err(d3_addr_err),
        .init_busy(d3_init_busy), .par_err(d3_par_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(logic wr, logic [7:0] a, logic [63:0] wd, logic [7:0] be,
                               logic [63:0] ex, logic err, logic par);
        op_t o;
        o.wr = wr; o.addr = a; o.wdata = wd; o.be = be; o.exp = ex; o.err = err; o.par = par;
        return o;
    endfunction

    function automatic logic [63:0] pat(int i);
        return {32'hC0DE0000 + 32'(i), 32'h0000F000 + 32'(i)};
    endfunction

    function automatic int op_at(int x, int gap, int n);
        if (x < 0 || x % (gap + 1) != 0 || x / (gap + 1) >= n) return -1;
        return x / (gap + 1);
    endfunction

    task automatic chk_dut(input string nm, input int d, input int c, input int gap, input int n,
                           input logic vld, input logic [63:0] rd, input logic err, input logic par);
        int   r;
        int   w;
        logic ev;
        logic ee;
        r  = op_at(c - d, gap, n);
        w  = op_at(c - 1, gap, n);
        ev = r >= 0 && !ops[r].wr;
        ee = (ev && ops[r].err) || (w >= 0 && ops[w].wr && ops[w].err);
        chk($sformatf("%s_vld@%0d", nm, c), 64'(vld), 64'(ev));
        chk($sformatf("%s_addr_err@%0d", nm, c), 64'(err), 64'(ee));
        if (ev) begin
            last_exp[d] = ops[r].exp;
            chk($sformatf("%s_par_err@%0d", nm, c), 64'(par), 64'(ops[r].par));
        end
        chk($sformatf("%s_rdata@%0d", nm, c), rd, last_exp[d]);
    endtask

    task automatic run_ops(input int n, input int gap);
        int last;
        int i;
        last = (n - 1) * (gap + 1);
        for (int c = 0; c <= last + 4; c++) begin
            @(negedge clka);
            if (c > 0) begin
                chk_dut("d1", 1, c, gap, n, d1_rsp_vld, d1_rsp_rdata, d1_addr_err, d1_par_err);
                chk_dut("d3", 3, c, gap, n, d3_rsp_vld, d3_rsp_rdata, d3_addr_err, d3_par_err);
            end
            i = op_at(c, gap, n);
            req_vld = i >= 0;
            if (i >= 0) begin
                req_wr    = ops[i].wr;
                req_addr  = ops[i].addr;
                req_wdata = ops[i].wdata;
                req_be    = ops[i].be;
            end
        end
    endtask

    task automatic reset_and_init(input int abort_at);
        int cnt1;
        int cnt3;
        bit done;
        cnt1 = 0; cnt3 = 0; done = 0;
        rst_n = 1'b0;
        req_vld = 1'b1; req_wr = 1'b1; req_addr = '0; req_wdata = '1; req_be = '1;
        last_exp[1] = '0;
        last_exp[3] = '0;
        repeat (2) @(negedge clka);
        chk("rst_d1_rsp_vld", 64'(d1_rsp_vld), 0);
        chk("rst_d1_rdata", d1_rsp_rdata, 0);
        chk("rst_d1_addr_err", 64'(d1_addr_err), 0);
        chk("rst_d1_par_err", 64'(d1_par_err), 0);
        chk("rst_d1_req_rdy", 64'(d1_req_rdy), 0);
        chk("rst_d3_rsp_vld", 64'(d3_rsp_vld), 0);
        chk("rst_d3_rdata", d3_rsp_rdata, 0);
        chk("rst_d3_req_rdy", 64'(d3_req_rdy), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clka);
            if (d1_init_busy) cnt1++;
            else if (cnt1 > 0) done = 1;
            if (d3_init_busy) cnt3++;
            chk("rdy_vs_busy", 64'(d1_req_rdy), 64'(!d1_init_busy));
            if (abort_at > 0 && cnt1 == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_d1_busy", 64'(d1_init_busy), 0);
                chk("abort_d3_busy", 64'(d3_init_busy), 0);
                chk("abort_d1_rdy", 64'(d1_req_rdy), 0);
                done = 1;
            end
        end
        req_vld = 1'b0;
        if (abort_at == 0) begin
            chk("init_cycles_d1", 64'(cnt1), 68);
            chk("init_cycles_d3", 64'(cnt3), 68);
            chk("ready_after_init", 64'(d1_req_rdy), 1);
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 8'd5,   64'hDEADBEEF_CAFEF00D, 8'hFF, '0, 0, 0);
        tbl[1]  = mk(1, 8'd5,   64'h11111111_11111111, 8'h0F, '0, 0, 0);
        tbl[2]  = mk(0, 8'd5,   '0, '0, 64'hDEADBEEF_11111111, 0, 0);
        tbl[3]  = mk(1, 8'd6,   64'hA5A5A5A5_A5A5A5A5, 8'h81, '0, 0, 0);
        tbl[4]  = mk(0, 8'd6,   '0, '0, 64'hA5000000_000000A5, 0, 0);
        tbl[5]  = mk(1, 8'd135, 64'h01234567_89ABCDEF, 8'hFF, '0, 0, 0);
        tbl[6]  = mk(0, 8'd135, '0, '0, 64'h01234567_89ABCDEF, 0, 0);
        tbl[7]  = mk(0, 8'd136, '0, '0, '0, 1, 0);
        tbl[8]  = mk(1, 8'd140, '1, 8'hFF, '0, 1, 0);
        tbl[9]  = mk(1, 8'd255, '1, 8'hFF, '0, 1, 0);
        tbl[10] = mk(0, 8'd0,   '0, '0, '0, 0, 0);
        tbl[11] = mk(0, 8'd134, '0, '0, '0, 0, 0);
        tbl[12] = mk(0, 8'd4,   '0, '0, '0, 0, 0);

        reset_and_init(0);
        for (int i = 0; i < 136; i++) ops[i] = mk(0, 8'(i), '0, '0, '0, 0, 0);
        run_ops(136, 0);

        for (int i = 0; i < 13; i++) ops[i] = tbl[i];
        run_ops(13, 4);

        ops[0] = mk(1, 8'd9,   64'h55555555_55555555, 8'hFF, '0, 0, 0);
        ops[1] = mk(0, 8'd9,   '0, '0, 64'h55555555_55555555, 0, 0);
        ops[2] = mk(1, 8'd9,   64'h01234567_89ABCDEF, 8'h3C, '0, 0, 0);
        ops[3] = mk(0, 8'd9,   '0, '0, 64'h55554567_89AB5555, 0, 0);
        ops[4] = mk(0, 8'd136, '0, '0, '0, 1, 0);
        ops[5] = mk(1, 8'd140, '1, 8'hFF, '0, 1, 0);
        ops[6] = mk(0, 8'd8,   '0, '0, '0, 0, 0);
        run_ops(7, 0);

        for (int i = 0; i < 8; i++) begin
            ops[i]     = mk(1, 8'(i), pat(i), 8'hFF, '0, 0, 0);
            ops[8 + i] = mk(0, 8'(i), '0, '0, pat(i), 0, 0);
        end
        run_ops(16, 0);

        reset_and_init(31);
        reset_and_init(0);
        for (int i = 0; i < 8; i++) ops[i] = mk(0, 8'(i), '0, '0, '0, 0, 0);
        ops[8] = mk(0, 8'd135, '0, '0, '0, 0, 0);
        ops[9] = mk(0, 8'd5,   '0, '0, '0, 0, 0);
        run_ops(10, 0);

`ifdef SPRAM_PARITY_EN
        dut.g_bank[1].u_bank.mem[1][9]  = ~dut.g_bank[1].u_bank.mem[1][9];
        dut3.g_bank[1].u_bank.mem[1][9] = ~dut3.g_bank[1].u_bank.mem[1][9];
        ops[0] = mk(0, 8'd3, '0, '0, 64'h200, 0, 1);
        ops[1] = mk(0, 8'd4, '0, '0, '0, 0, 0);
        run_ops(2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
